// File: rtl/encoder4_2_reg.sv
// Registered 4:2 priority encoder with a pending-request register and a vld/rdy output handshake.
// Define ENCODER_ROUND_ROBIN_EN to replace fixed priority (d3 > d2 > d1 > d0) with round-robin selection.
//
// state | meaning
// ------+-------------------------------------------------------
// IDLE  | no code presented (vld=0); loads a code when pend != 0
// OUT   | code presented on s1/s0 (vld=1); leaves on vld && rdy
module encoder4_2_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic d3,
    input  logic d2,
    input  logic d1,
    input  logic d0,
    input  logic rdy,
    output logic vld,
    output logic s1,
    output logic s0,
    output logic multi,
    output logic drop
);

    typedef enum logic {
        IDLE = 1'b0,
        OUT  = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] pend, pend_nxt, req, clr;
    logic [1:0] code, pick;
    logic       load, hs, multi_nxt, drop_nxt;

    assign req = {d3, d2, d1, d0};
    assign hs  = (state == OUT) && rdy;
    assign clr = hs ? (4'b0001 << code) : 4'b0000;

    // A request arriving in the handshake cycle re-sets its bit after the clear.
    assign pend_nxt  = (pend & ~clr) | req;
    assign drop_nxt  = |(req & pend & ~clr);
    assign multi_nxt = (pend & (pend - 4'd1)) != 4'd0;

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [1:0] last;
    logic       found;
    logic [1:0] idx;

    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last - 2'(k);
            if (!found && pend[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 2'd0;
        end else if (load) begin
            last <= pick;
        end
    end
`else
    always_comb begin
        pick = 2'd0;
        if (pend[3])      pick = 2'd3;
        else if (pend[2]) pick = 2'd2;
        else if (pend[1]) pick = 2'd1;
        else              pick = 2'd0;
    end
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (pend != 4'd0) begin
                    state_nxt = OUT;
                    load      = 1'b1;
                end
            end
            OUT: begin
                if (rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= 4'd0;
            code  <= 2'd0;
            multi <= 1'b0;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            drop  <= drop_nxt;
            if (load) begin
                code  <= pick;
                multi <= multi_nxt;
            end
        end
    end

    assign vld = (state == OUT);
    assign s1  = code[1];
    assign s0  = code[0];

endmodule

// File: tb/tb_encoder4_2_reg.sv
// Scoreboard bench for encoder4_2_reg: directed scenarios plus random traffic against a behavioural model.
// Honours ENCODER_ROUND_ROBIN_EN to match the DUT build.
module tb_encoder4_2_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic d3 = 1'b0, d2 = 1'b0, d1 = 1'b0, d0 = 1'b0;
    logic rdy = 1'b0;
    logic vld, s1, s0, multi, drop;

    encoder4_2_reg dut (
        .clk(clk), .rst_n(rst_n),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .rdy(rdy),
        .vld(vld), .s1(s1), .s0(s0), .multi(multi), .drop(drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit vld;
        int code;
        bit multi;
        bit drop;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model: the set of pending request indices, whether a grant is on offer,
    // and which index that grant is.
    bit   m_pend[4];
    bit   m_busy;
    int   m_code;
    bit   m_multi;
    int   m_last;

    function automatic int n_pending();
        int n = 0;
        for (int i = 0; i < 4; i++) n += m_pend[i] ? 1 : 0;
        return n;
    endfunction

    function automatic int choose();
`ifdef ENCODER_ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++) begin
            int i = (m_last - k + 8) % 4;
            if (m_pend[i]) return i;
        end
`else
        for (int i = 3; i >= 0; i--) if (m_pend[i]) return i;
`endif
        return 0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
        m_busy  = 1'b0;
        m_code  = 0;
        m_multi = 1'b0;
        m_last  = 0;
    endfunction

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle's inputs and predict the outputs after the next rising edge.
    task automatic step(logic [3:0] d, logic r);
        exp_t e;
        int   taken;
        bit   dropped;
        {d3, d2, d1, d0} = d;
        rdy = r;
        taken = (m_busy && r) ? m_code : -1;
        dropped = 1'b0;
        for (int i = 0; i < 4; i++)
            if (d[i] && m_pend[i] && i != taken) dropped = 1'b1;
        if (!m_busy) begin
            if (n_pending() > 0) begin
                m_code  = choose();
                m_multi = n_pending() >= 2;
                m_last  = m_code;
                m_busy  = 1'b1;
            end
        end else if (r) begin
            m_busy = 1'b0;
        end
        if (taken >= 0) m_pend[taken] = 1'b0;
        for (int i = 0; i < 4; i++) if (d[i]) m_pend[i] = 1'b1;
        e.vld = m_busy; e.code = m_code; e.multi = m_multi; e.drop = dropped;
        exp_q.push_back(e);
    endtask

    task automatic cycle(logic [3:0] d, logic r);
        @(negedge clk);
        step(d, r);
    endtask

    task automatic do_reset(int hold);
        @(negedge clk);
        rst_n = 1'b0;
        {d3, d2, d1, d0} = 4'd0;
        rdy = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check("rst_vld", vld, 0);
        check("rst_s1s0", {s1, s0}, 0);
        check("rst_multi", multi, 0);
        check("rst_drop", drop, 0);
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
        step(4'd0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("vld", vld, e.vld);
                check("drop", drop, e.drop);
                if (e.vld) begin
                    check("code", {s1, s0}, e.code);
                    check("multi", multi, e.multi);
                end
            end
        end
    end

    initial begin : stimulus
        int tries;
        model_reset();
        do_reset(2);

        // single d1 pulse, consumer always ready
        cycle(4'b0010, 1);
        repeat (4) cycle(4'b0000, 1);

        // d0 and d2 together
        cycle(4'b0101, 1);
        repeat (6) cycle(4'b0000, 1);

        // code held while a higher request arrives with rdy low
        cycle(4'b0010, 0);
        repeat (3) cycle(4'b0000, 0);
        cycle(4'b1000, 0);
        repeat (3) cycle(4'b0000, 0);
        repeat (6) cycle(4'b0000, 1);

        // d2 held continuously
        repeat (10) cycle(4'b0100, 1);
        repeat (3) cycle(4'b0000, 1);

        // all requests held (round-robin sequence when enabled)
        repeat (12) cycle(4'b1111, 1);
        repeat (8) cycle(4'b0000, 1);

        // reset in the middle of presenting code 11
        cycle(4'b1000, 0);
        tries = 0;
        while (!(m_busy && m_code == 3) && tries < 20) begin
            cycle(4'b0000, 0);
            tries++;
        end
        check("reach_code3", (m_busy && m_code == 3) ? 1 : 0, 1);
        cycle(4'b0000, 0);
        do_reset(2);
        repeat (6) cycle(4'b0000, 1);

        for (int n = 0; n < 3000; n++) begin
            logic [3:0] d;
            for (int b = 0; b < 4; b++) d[b] = ($urandom_range(0, 3) == 0);
            if (n == 1500) do_reset(1);
            cycle(d, ($urandom_range(0, 9) < 7));
        end
        repeat (8) cycle(4'b0000, 1);

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
